// File: rtl/stm_segment_scheduler.sv
// Segment scheduler for a two-segment pattern player.
// Steps the pattern index on UPDATE ticks and swaps segments on cycle boundaries.
module stm_segment_scheduler #(
  parameter int IDX_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 UPDATE,
  input  logic                 UPDATE_SETTINGS,
  input  logic                 REQ_RD_SEGMENT,
  input  logic [31:0]          REP,
  input  logic [IDX_WIDTH-1:0] CYCLE_0,
  input  logic [IDX_WIDTH-1:0] CYCLE_1,
  input  logic [31:0]          FREQ_DIV_0,
  input  logic [31:0]          FREQ_DIV_1,
  output logic                 SEGMENT,
  output logic [IDX_WIDTH-1:0] IDX,
  output logic                 IDX_VALID,
  output logic                 SWAP,
  output logic                 STOPPED
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PENDING,
    HOLD
  } state_t;

  state_t               state_q, state_n;
  logic                 now_q, now_n;
  logic                 sh_seg;
  logic [31:0]          sh_rep;
  logic [IDX_WIDTH-1:0] sh_cyc0, sh_cyc1;
  logic [31:0]          sh_div0, sh_div1;
  logic [IDX_WIDTH-1:0] cyc_q, cyc_n;
  logic [31:0]          dm1_q, dm1_n;
  logic [31:0]          rep_q, rep_n;
  logic [31:0]          div_q, div_n;
  logic [31:0]          cnt_q, cnt_n;
  logic                 seg_q, seg_n;
  logic [IDX_WIDTH-1:0] idx_q, idx_n;
  logic                 vld_q, vld_n;
  logic                 swp_q, swp_n;
  logic                 stp_q, stp_n;
  logic                 apply;
  logic [31:0]          sh_div;

  assign sh_div = sh_seg ? sh_div1 : sh_div0;

  always_comb begin
    state_n = state_q;
    now_n   = now_q;
    cyc_n   = cyc_q;
    dm1_n   = dm1_q;
    rep_n   = rep_q;
    div_n   = div_q;
    cnt_n   = cnt_q;
    seg_n   = seg_q;
    idx_n   = idx_q;
    vld_n   = 1'b0;
    swp_n   = 1'b0;
    stp_n   = stp_q;
    apply   = 1'b0;
    if (UPDATE) begin
      if (state_q == PENDING && now_q) begin
        apply = 1'b1;
      end else if (state_q == PLAY || state_q == PENDING) begin
        if (div_q == dm1_q) begin
          div_n = '0;
          if (idx_q == cyc_q) begin
            if (state_q == PENDING) begin
              apply = 1'b1;
            end else begin
              cnt_n = cnt_q + 32'd1;
              if (rep_q != '1 && cnt_q == rep_q) begin
                state_n = HOLD;
                stp_n   = 1'b1;
              end else begin
                idx_n = '0;
                vld_n = 1'b1;
              end
            end
          end else begin
            idx_n = idx_q + IDX_WIDTH'(1);
            vld_n = 1'b1;
          end
        end else begin
          div_n = div_q + 32'd1;
        end
      end
    end
    if (apply) begin
      state_n = PLAY;
      now_n   = 1'b0;
      seg_n   = sh_seg;
      idx_n   = '0;
      div_n   = '0;
      cnt_n   = '0;
      vld_n   = 1'b1;
      swp_n   = 1'b1;
      stp_n   = 1'b0;
      cyc_n   = sh_seg ? sh_cyc1 : sh_cyc0;
      dm1_n   = (sh_div == '0) ? '0 : sh_div - 32'd1;
      rep_n   = sh_rep;
    end
    // Requests from a stopped player apply on the next tick, not a boundary
    if (UPDATE_SETTINGS) begin
      now_n   = (state_n == IDLE) || (state_n == HOLD) ||
                (state_n == PENDING && now_q);
      state_n = PENDING;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      now_q   <= 1'b0;
      cyc_q   <= '0;
      dm1_q   <= '0;
      rep_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= 1'b0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      swp_q   <= 1'b0;
      stp_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      now_q   <= now_n;
      cyc_q   <= cyc_n;
      dm1_q   <= dm1_n;
      rep_q   <= rep_n;
      div_q   <= div_n;
      cnt_q   <= cnt_n;
      seg_q   <= seg_n;
      idx_q   <= idx_n;
      vld_q   <= vld_n;
      swp_q   <= swp_n;
      stp_q   <= stp_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_seg  <= 1'b0;
      sh_rep  <= '0;
      sh_cyc0 <= '0;
      sh_cyc1 <= '0;
      sh_div0 <= '0;
      sh_div1 <= '0;
    end else if (UPDATE_SETTINGS) begin
      sh_seg  <= REQ_RD_SEGMENT;
      sh_rep  <= REP;
      sh_cyc0 <= CYCLE_0;
      sh_cyc1 <= CYCLE_1;
      sh_div0 <= FREQ_DIV_0;
      sh_div1 <= FREQ_DIV_1;
    end
  end

  assign SEGMENT   = seg_q;
  assign IDX       = idx_q;
  assign IDX_VALID = vld_q;
  assign SWAP      = swp_q;
  assign STOPPED   = stp_q;

endmodule

// File: tb/tb_stm_segment_scheduler.sv
// Testbench for stm_segment_scheduler.
// Vector table, scripted corner cases and random traffic against a tick-count model.
module tb_stm_segment_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        UPDATE = 1'b0;
  logic        UPDATE_SETTINGS = 1'b0;
  logic        REQ_RD_SEGMENT = 1'b0;
  logic [31:0] REP = '0;
  logic [15:0] CYCLE_0 = '0;
  logic [15:0] CYCLE_1 = '0;
  logic [31:0] FREQ_DIV_0 = '0;
  logic [31:0] FREQ_DIV_1 = '0;
  logic        SEGMENT;
  logic [15:0] IDX;
  logic        IDX_VALID;
  logic        SWAP;
  logic        STOPPED;

  int checks = 0;
  int errors = 0;

  stm_segment_scheduler #(.IDX_WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE),
    .UPDATE_SETTINGS(UPDATE_SETTINGS),
    .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .REP(REP),
    .CYCLE_0(CYCLE_0), .CYCLE_1(CYCLE_1),
    .FREQ_DIV_0(FREQ_DIV_0), .FREQ_DIV_1(FREQ_DIV_1),
    .SEGMENT(SEGMENT), .IDX(IDX), .IDX_VALID(IDX_VALID),
    .SWAP(SWAP), .STOPPED(STOPPED)
  );

  always #5 CLK = ~CLK;

  // Model: playback position is derived from ticks since segment start
  bit     m_act, m_done, m_seg, e_vld, e_swp;
  longint m_cyc, m_div, m_rep, m_n;
  bit     p_v, p_seg;
  longint p_cyc, p_div, p_rep;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_done = 0; m_seg = 0; e_vld = 0; e_swp = 0;
    m_cyc = 0; m_div = 1; m_rep = 0; m_n = 0;
    p_v = 0; p_seg = 0; p_cyc = 0; p_div = 1; p_rep = 0;
  endtask

  task automatic model_apply();
    m_act = 1; m_done = 0; m_seg = p_seg;
    m_cyc = p_cyc; m_div = p_div; m_rep = p_rep; m_n = 0;
    p_v = 0; e_vld = 1; e_swp = 1;
  endtask

  task automatic model_step(bit upd, bit us, bit seg, logic [31:0] rep,
                            logic [15:0] c0, logic [31:0] d0,
                            logic [15:0] c1, logic [31:0] d1);
    longint n1, per;
    longint unsigned d;
    e_vld = 0; e_swp = 0;
    if (upd) begin
      if (p_v && (!m_act || m_done)) model_apply();
      else if (m_act && !m_done) begin
        n1  = m_n + 1;
        per = m_div * (m_cyc + 1);
        m_n = n1;
        if (n1 % m_div == 0) begin
          if (n1 % per == 0) begin
            if (p_v) model_apply();
            else if (m_rep != 64'hFFFFFFFF && n1 / per == m_rep + 1)
              m_done = 1;
            else e_vld = 1;
          end else e_vld = 1;
        end
      end
    end
    if (us) begin
      p_v = 1; p_seg = seg; p_rep = longint'(rep);
      p_cyc = seg ? longint'(c1) : longint'(c0);
      d = seg ? d1 : d0;
      p_div = (d == 0) ? 1 : longint'(d);
    end
  endtask

  function automatic longint m_idx();
    if (!m_act) return 0;
    if (m_done) return m_cyc;
    return (m_n / m_div) % (m_cyc + 1);
  endfunction

  task automatic check_model(string tag);
    chk({tag, ".seg"}, SEGMENT, m_seg);
    chk({tag, ".idx"}, IDX, m_idx());
    chk({tag, ".vld"}, IDX_VALID, e_vld);
    chk({tag, ".swap"}, SWAP, e_swp);
    chk({tag, ".stop"}, STOPPED, !m_act || m_done);
  endtask

  task automatic tick(bit upd, bit us, bit seg, logic [31:0] rep,
                      logic [15:0] c0, logic [31:0] d0,
                      logic [15:0] c1, logic [31:0] d1);
    UPDATE = upd; UPDATE_SETTINGS = us; REQ_RD_SEGMENT = seg;
    REP = rep; CYCLE_0 = c0; FREQ_DIV_0 = d0;
    CYCLE_1 = c1; FREQ_DIV_1 = d1;
    @(posedge CLK);
    model_step(upd, us, seg, rep, c0, d0, c1, d1);
    @(negedge CLK);
  endtask

  task automatic upd_only();
    tick(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a falling edge; reset is asserted between clock edges
  task automatic do_reset();
    UPDATE = 0; UPDATE_SETTINGS = 0;
    RST_N = 1'b0;
    #1;
    chk("rst.seg", SEGMENT, 0);
    chk("rst.idx", IDX, 0);
    chk("rst.vld", IDX_VALID, 0);
    chk("rst.swap", SWAP, 0);
    chk("rst.stop", STOPPED, 1);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  typedef struct {
    bit          upd, us, seg;
    logic [31:0] rep;
    logic [15:0] c0;
    logic [31:0] d0;
    logic [15:0] c1;
    logic [31:0] d1;
    bit          x_seg;
    logic [15:0] x_idx;
    bit          x_vld, x_swp, x_stp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int swaps, seg1_seen, n;
    bit seen;
    tbl[0]  = '{0,1,0,1,2,0,0,0,       0,0,0,0,1};
    tbl[1]  = '{1,0,0,0,0,0,0,0,       0,0,1,1,0};
    tbl[2]  = '{0,0,0,0,0,0,0,0,       0,0,0,0,0};
    tbl[3]  = '{1,0,0,0,0,0,0,0,       0,1,1,0,0};
    tbl[4]  = '{1,0,0,0,0,0,0,0,       0,2,1,0,0};
    tbl[5]  = '{1,0,0,0,0,0,0,0,       0,0,1,0,0};
    tbl[6]  = '{1,0,0,0,0,0,0,0,       0,1,1,0,0};
    tbl[7]  = '{1,0,0,0,0,0,0,0,       0,2,1,0,0};
    tbl[8]  = '{1,0,0,0,0,0,0,0,       0,2,0,0,1};
    tbl[9]  = '{1,0,0,0,0,0,0,0,       0,2,0,0,1};
    tbl[10] = '{0,1,1,32'hFFFFFFFF,0,0,0,2, 0,2,0,0,1};
    tbl[11] = '{1,0,0,0,0,0,0,0,       1,0,1,1,0};
    tbl[12] = '{1,0,0,0,0,0,0,0,       1,0,0,0,0};
    tbl[13] = '{1,0,0,0,0,0,0,0,       1,0,1,0,0};
    tbl[14] = '{1,1,0,0,1,1,0,0,       1,0,0,0,0};
    tbl[15] = '{1,0,0,0,0,0,0,0,       0,0,1,1,0};
    tbl[16] = '{1,0,0,0,0,0,0,0,       0,1,1,0,0};
    tbl[17] = '{1,0,0,0,0,0,0,0,       0,1,0,0,1};

    model_reset();
    @(negedge CLK);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].upd, tbl[i].us, tbl[i].seg, tbl[i].rep,
           tbl[i].c0, tbl[i].d0, tbl[i].c1, tbl[i].d1);
      chk($sformatf("tbl%0d.seg", i), SEGMENT, tbl[i].x_seg);
      chk($sformatf("tbl%0d.idx", i), IDX, tbl[i].x_idx);
      chk($sformatf("tbl%0d.vld", i), IDX_VALID, tbl[i].x_vld);
      chk($sformatf("tbl%0d.swap", i), SWAP, tbl[i].x_swp);
      chk($sformatf("tbl%0d.stop", i), STOPPED, tbl[i].x_stp);
    end

    // Long infinite segment, then a finite request mid-cycle
    do_reset();
    tick(0, 1, 0, 32'hFFFFFFFF, 15, 1, 0, 0);
    check_model("inf.arm");
    for (int i = 0; i < 22; i++) begin
      upd_only();
      check_model("inf");
    end
    chk("inf.at5", IDX, 5);
    tick(0, 1, 1, 0, 15, 1, 3, 3);
    check_model("req1");
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      upd_only();
      check_model("swap1");
      if (SWAP && SEGMENT) seen = 1;
    end
    chk("swap1.seen", seen, 1);
    chk("hold.idx", IDX, 3);
    chk("hold.stop", STOPPED, 1);

    tick(0, 1, 0, 32'hFFFFFFFF, 15, 1, 0, 0);
    upd_only();
    check_model("resume");
    chk("resume.swap", SWAP, 1);
    chk("resume.seg", SEGMENT, 0);

    // Overwritten request: only the last applies
    tick(0, 1, 1, 0, 15, 1, 3, 3);
    tick(0, 1, 0, 32'hFFFFFFFF, 15, 1, 3, 3);
    swaps = 0; seg1_seen = 0;
    for (int i = 0; i < 20; i++) begin
      upd_only();
      check_model("ovr");
      swaps += SWAP;
      seg1_seen += SEGMENT;
    end
    chk("ovr.swaps", swaps, 1);
    chk("ovr.seg1", seg1_seen, 0);

    // Coincident request with tick, then reset while pending
    n = int'(IDX);
    tick(1, 1, 1, 0, 15, 1, 3, 3);
    check_model("coin");
    chk("coin.step", IDX, (n + 1) % 16);
    do_reset();
    swaps = 0;
    for (int i = 0; i < 10; i++) begin
      upd_only();
      check_model("postrst");
      swaps += SWAP;
    end
    chk("postrst.swaps", swaps, 0);
    chk("postrst.stop", STOPPED, 1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] r;
      if ($urandom_range(499) == 0) do_reset();
      case ($urandom_range(3))
        0: r = 0;
        1: r = 1;
        2: r = 2;
        default: r = 32'hFFFFFFFF;
      endcase
      tick($urandom_range(1), $urandom_range(24) == 0,
           $urandom_range(1), r,
           16'($urandom_range(5)), $urandom_range(3),
           16'($urandom_range(5)), $urandom_range(3));
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
